fetch_unit: RTL and testbench

//   Instruction fetch front end that feeds the control/decoder stage.
//   - Holds the PC and issues word fetches to instruction memory over a valid/ready request channel.
//   - Buffers returned words in a small FIFO and presents them to the decoder with valid/ready,

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end: PC, imem request channel, small
//            instruction FIFO to the decoder, and branch redirect handling.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    input  logic        pc_we,
    input  logic [15:0] branch_imm
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_STALL = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_req_pc;
    logic               r_drop;
    logic               w_drop_next;
    logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]        r_fifo_word [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;

    logic               w_head_valid;
    logic [31:0]        w_head_pc;
    logic [31:0]        w_head_word;
    logic               w_accept;
    logic               w_pop;
    logic               w_redirect;
    logic               w_push;
    logic               w_keep_wait;
    logic [31:0]        w_target;

    assign w_head_valid = (r_count != '0);
    assign w_head_pc    = r_fifo_pc[r_rd_ptr];
    assign w_head_word  = r_fifo_word[r_rd_ptr];
    assign w_accept     = (r_state == c_ST_FETCH) && imem_req_ready;
    assign w_pop        = w_head_valid && instr_ready;
    assign w_redirect   = w_pop && pc_we;
    // Stale responses (drop) and responses racing a redirect never enter the FIFO.
    assign w_push       = (r_state == c_ST_WAIT) && imem_rsp_valid && !r_drop && !w_redirect;
    // A redirect that leaves a request still in flight must wait out its response.
    assign w_keep_wait  = w_accept || ((r_state == c_ST_WAIT) && !imem_rsp_valid);
    assign w_target     = w_head_pc + 32'd4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        case (r_state)
            c_ST_IDLE:  w_state_next = c_ST_FETCH;
            c_ST_FETCH: if (w_accept) w_state_next = c_ST_WAIT;
            c_ST_WAIT: begin
                if (imem_rsp_valid) begin
                    w_drop_next  = 1'b0;
                    w_state_next = (w_count_next < c_DEPTH) ? c_ST_FETCH : c_ST_STALL;
                end
            end
            c_ST_STALL: if (w_pop) w_state_next = c_ST_FETCH;
            default:    w_state_next = c_ST_IDLE;
        endcase
        if (w_redirect) begin
            w_state_next = w_keep_wait ? c_ST_WAIT : c_ST_FETCH;
            if (w_keep_wait) begin
                w_drop_next = 1'b1;
            end
        end
    end

    always_comb begin
        imem_req_valid = (r_state == c_ST_FETCH);
        imem_addr      = r_fetch_pc;
        instr_valid    = w_head_valid;
        instr          = w_head_valid ? w_head_word : '0;
        instr_pc       = w_head_valid ? w_head_pc : '0;
        opcode         = w_head_valid ? w_head_word[31:26] : '0;
        funct          = w_head_valid ? w_head_word[5:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_drop     <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_drop <= w_drop_next;
            if (w_accept) begin
                r_req_pc <= r_fetch_pc;
            end
            if (w_redirect) begin
                r_fetch_pc <= w_target;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_count <= w_count_next;
            end
        end
    end

    // Storage needs no reset: the outputs are gated by the entry count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
            r_fifo_word[r_wr_ptr] <= imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_count == c_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit (directed scenarios).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [5:0]  opcode, funct;
    logic        pc_we;
    logic [15:0] branch_imm;

    // Second instance exercising PC wrap-around.
    logic        wr_req_valid, wr_req_ready, wr_rsp_valid, wr_instr_valid, wr_instr_ready, wr_pc_we;
    logic [31:0] wr_addr, wr_rsp_addr, wr_instr, wr_instr_pc;
    logic [5:0]  wr_opcode, wr_funct;
    logic [15:0] wr_branch_imm;

    logic [3:0]  mem_lat;
    logic [3:0]  m_cnt;
    logic [31:0] m_addr;

    logic [31:0] exp_addr[$];
    logic [63:0] exp_ins[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_req    = 0;
    int n_pop    = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .opcode(opcode), .funct(funct), .pc_we(pc_we), .branch_imm(branch_imm)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(wr_req_valid), .imem_req_ready(wr_req_ready), .imem_addr(wr_addr),
        .imem_rsp_valid(wr_rsp_valid), .imem_rsp_data(mem_word(wr_rsp_addr)),
        .instr_valid(wr_instr_valid), .instr_ready(wr_instr_ready), .instr(wr_instr), .instr_pc(wr_instr_pc),
        .opcode(wr_opcode), .funct(wr_funct), .pc_we(wr_pc_we), .branch_imm(wr_branch_imm)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2], 20'hA5C3F, a[7:2]} ^ 32'h0800_0001;
    endfunction

    // Memory models: fixed latency from acceptance to response.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= '0;
            m_addr <= '0;
        end else if (imem_req_valid && imem_req_ready) begin
            m_cnt  <= mem_lat;
            m_addr <= imem_addr;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 4'd1;
        end
    end
    assign imem_rsp_valid = (m_cnt == 4'd1);
    assign imem_rsp_data  = mem_word(m_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_rsp_valid <= 1'b0;
            wr_rsp_addr  <= '0;
        end else begin
            wr_rsp_valid <= wr_req_valid && wr_req_ready;
            wr_rsp_addr  <= wr_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: requests and consumed instructions against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                n_req++;
                if (exp_addr.size() == 0) check("req_unexpected", imem_addr, 32'hDEAD_BEEF);
                else check("req_addr", imem_addr, exp_addr.pop_front());
            end
            if (instr_valid && instr_ready) begin
                n_pop++;
                if (exp_ins.size() == 0) begin
                    check("ins_unexpected", instr_pc, 32'hDEAD_BEEF);
                end else begin
                    logic [63:0] e;
                    e = exp_ins.pop_front();
                    check("ins_pc", instr_pc, e[63:32]);
                    check("ins_word", instr, e[31:0]);
                    check("ins_opcode", {26'd0, opcode}, {26'd0, e[31:26]});
                    check("ins_funct", {26'd0, funct}, {26'd0, e[5:0]});
                end
            end
        end
    end

    task automatic push_addrs(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(first + 32'(4 * i));
    endtask

    task automatic push_ins(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = first + 32'(4 * i);
            exp_ins.push_back({p, mem_word(p)});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instr_ready = 1'b0;
        pc_we = 1'b0;
        branch_imm = '0;
        imem_req_ready = 1'b1;
        exp_addr.delete();
        exp_ins.delete();
        n_req = 0;
        n_pop = 0;
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fields", {20'd0, opcode, funct}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int cyc;
        wr_req_ready = 1'b1; wr_instr_ready = 1'b1; wr_pc_we = 1'b0; wr_branch_imm = '0;
        mem_lat = 4'd1;

        // Free-running fetch, latency, throughput and wrap instance.
        do_reset();
        push_addrs(32'h0, 8);
        push_ins(32'h0, 8);
        instr_ready = 1'b1;
        check("a_req_valid_c1", {31'd0, imem_req_valid}, 32'd1);
        check("a_addr_c1", imem_addr, 32'h0);
        check("w_addr_c1", wr_addr, 32'hFFFF_FFFC);
        tick();
        check("a_instr_valid_c2", {31'd0, instr_valid}, 32'd0);
        tick();
        check("a_instr_valid_c3", {31'd0, instr_valid}, 32'd1);
        check("a_instr_pc_c3", instr_pc, 32'h0);
        check("w_req_valid_c3", {31'd0, wr_req_valid}, 32'd1);
        check("w_addr_c3", wr_addr, 32'h0000_0000);
        check("w_instr_pc_c3", wr_instr_pc, 32'hFFFF_FFFC);
        check("w_instr_c3", wr_instr, mem_word(32'hFFFF_FFFC));
        cyc = 0;
        for (int k = 0; k < 40 && n_pop < 6; k++) begin tick(); cyc++; end
        check("a_pop_count", {31'd0, n_pop >= 6}, 32'd1);
        check("a_throughput_cycles", 32'(cyc), 32'd11);

        // Backpressure: two requests then stall; pc_we without consume is ignored.
        do_reset();
        push_addrs(32'h0, 3);
        push_ins(32'h0, 3);
        pc_we = 1'b1;
        branch_imm = 16'h0010;
        repeat (10) tick();
        check("b_req_count", 32'(n_req), 32'd2);
        check("b_stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("b_head_pc", instr_pc, 32'h0);
        pc_we = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("b_resume_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("b_resume_addr", imem_addr, 32'h8);

        // Branch from head pc 0x8 with imm -2 -> target 0x4.
        repeat (4) tick();
        check("c_req_count", 32'(n_req), 32'd3);
        instr_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        pc_we = 1'b1;
        branch_imm = 16'hFFFE;
        check("c_head_pc", instr_pc, 32'h8);
        tick();
        pc_we = 1'b0;
        check("c_redirect_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("c_redirect_addr", imem_addr, 32'h4);
        check("c_flush_instr_valid", {31'd0, instr_valid}, 32'd0);
        push_addrs(32'h4, 6);
        push_ins(32'h4, 4);
        imem_req_ready = 1'b1;
        for (int k = 0; k < 40 && n_pop < 5; k++) tick();
        check("c_pop_count", {31'd0, n_pop >= 5}, 32'd1);

        // Redirect while a response is in flight (3-cycle memory).
        mem_lat = 4'd3;
        do_reset();
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        push_addrs(32'h40, 6);
        push_ins(32'h0, 1);
        push_ins(32'h40, 4);
        for (int k = 0; k < 20 && !instr_valid; k++) tick();
        check("d_first_valid", {31'd0, instr_valid}, 32'd1);
        for (int k = 0; k < 20 && imem_req_valid; k++) tick();
        check("d_in_wait", {31'd0, imem_req_valid}, 32'd0);
        instr_ready = 1'b1;
        pc_we = 1'b1;
        branch_imm = 16'h000F;
        tick();
        pc_we = 1'b0;
        check("d_target_addr", imem_addr, 32'h40);
        check("d_flush_instr_valid", {31'd0, instr_valid}, 32'd0);
        for (int k = 0; k < 60 && n_pop < 3; k++) tick();
        check("d_pop_count", {31'd0, n_pop >= 3}, 32'd1);

        // Reset in the middle of a WAIT with a buffered word.
        instr_ready = 1'b0;
        for (int k = 0; k < 30 && !(instr_valid && !imem_req_valid); k++) tick();
        check("e_pre_reset_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        mem_lat = 4'd1;
        do_reset();
        push_addrs(32'h0, 4);
        check("e_req_valid_c1", {31'd0, imem_req_valid}, 32'd1);
        check("e_addr_c1", imem_addr, 32'h0);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
